multi_cycle_adder: RTL and testbench
====================================

# multi_cycle_adder

Parametrised multi-cycle ripple adder that adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock. The carry is held in a register between chunks. It is the sequential successor of the team's fixed 4-bit combinational adder: any width, area traded for latency, and a start/busy/done handshake. It sits behind the datapath sequencer wherever a wide add is not timing-critical.

## Interface
- WIDTH, 16, operand and sum width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK, WIDTH/CHUNK, derived local parameter; the number of add cycles.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- X  in  WIDTH  operand A; captured when start is accepted.
- Y  in  WIDTH  operand B; captured when start is accepted.
- Z  in  1  carry-in; captured when start is accepted.
- S  out  WIDTH  registered sum of the last completed operation.
- C  out  1  registered carry-out of the last completed operation.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- V  out  1  signed overflow; present only with MULTI_CYCLE_ADDER_OVF_EN defined.

## Operation
- States are IDLE and RUN.
- Reset: state=IDLE, chunk counter=0, working regs=0, carry reg=0. Outputs S=0, C=0, busy=0, done=0, V=0.
- IDLE & start=1: latch X→A, Y→B, Z→carry; clear working sum; counter=0; go to RUN.
- IDLE & start=0: hold.
- Each RUN cycle k (k=0..NCHUNK-1):
  - Compute {cout, sum} = A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + carry.
  - Write sum into working bits [k*CHUNK +: CHUNK].
  - carry ← cout.
  - counter ← k+1.
- When k = NCHUNK-1:
  - S ← full working sum, including this chunk.
  - C ← cout.
  - V ← carry into MSB XOR cout.
  - done ← 1; state → IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. C is bit WIDTH of X+Y+Z.
- S, C and V change only on the completion edge. Partial sums are never visible on S.
- start while busy=1 is ignored. Operands are not re-captured and no queueing occurs.
- Operand inputs may change freely after the accept edge.
- rst mid-RUN aborts immediately. All outputs and state return to reset values, and no done is produced.

## Timing
- Accept edge E0: IDLE with start=1. busy rises after E0.
- Chunk k is computed at edge E(k+1).
- At edge E(NCHUNK): S, C, V update; done=1; busy=0.
- Latency: done is high in the cycle following E(NCHUNK), i.e. NCHUNK cycles after the accept edge.
- done is low at every other time. It cannot be held high across consecutive cycles; back-to-back operations produce separate pulses.
- Back-to-back operation: start may be high while done=1 (state is IDLE) and is accepted at E(NCHUNK+1). Throughput is one result per NCHUNK+1 cycles.
- CHUNK=WIDTH gives NCHUNK=1. Single RUN cycle; done one cycle after accept.
- CHUNK=1 gives a bit-serial adder with WIDTH cycles of RUN.
- Counter width is $clog2(NCHUNK), minimum 1. The counter never exceeds NCHUNK-1.

## Configuration
- Macro MULTI_CYCLE_ADDER_OVF_EN.
- Defined: port V exists and reports two's-complement overflow of the completed add (carry into MSB XOR carry out of MSB). V resets to 0 and updates only at completion.
- Undefined: port V and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- Reset: assert rst with start=1 → S=0, C=0, busy=0, done=0 (V=0); no accept while rst=1.
- Full carry ripple: X=16'hA5A5, Y=16'h5A5A, Z=1 → S=16'h0000, C=1. done pulses exactly 4 cycles after the accept edge; busy is high for exactly 4 cycles.
- No carry / overflow:
  - X=16'hFFFF, Y=16'h0000, Z=0 → S=16'hFFFF, C=0, V=0.
  - X=16'h7FFF, Y=16'h0001, Z=0 → S=16'h8000, C=0, V=1 (macro defined).
- Ignored start: accept X=16'h0003, Y=16'h0004, Z=0. Pulse start with X=16'h1111 during busy → result S=16'h0007; only one done pulse. Then start held through done → second op accepted on the next edge.
- Abort: rst for one cycle at RUN chunk 2 → S=0, busy=0, no done. A following X=16'h000F, Y=16'h0001, Z=0 → S=16'h0010, C=0.
- Boundary instances:
  - CHUNK=16: X=16'hFFFF, Y=16'h0001, Z=0 → S=16'h0000, C=1, done 1 cycle after accept.
  - CHUNK=1: same operands → done 16 cycles after accept.

Source files
------------

// File: rtl/multi_cycle_adder.sv
// rtl/multi_cycle_adder.sv - multi-cycle ripple adder, CHUNK bits per clock, start/busy/done handshake
//
// Adds X + Y + Z (WIDTH bits plus carry-in). The add runs CHUNK bits per cycle
// over NCHUNK = WIDTH/CHUNK cycles. The carry is kept in a register between chunks.
// Optional macro: MULTI_CYCLE_ADDER_OVF_EN adds output V (signed overflow).
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only while idle
//   X, Y   in   WIDTH-bit operands, captured on accept
//   Z      in   carry-in, captured on accept
//   S      out  registered sum of the last completed operation
//   C      out  registered carry-out of the last completed operation
//   busy   out  high while the add is running
//   done   out  one-cycle completion pulse
//   V      out  signed overflow of the last completed operation (macro only)
module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Z,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             busy,
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    output logic             done,
    output logic             V
`else
    output logic             done
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  a_q, b_q, work_q;
    logic              carry_q;

    int                shift;
    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic [CHUNK:0]    sum_full;
    logic              cout;
    logic [WIDTH-1:0]  work_d;
    logic              is_last;

    always_comb begin
        state_d  = state_q;
        shift    = int'(cnt_q) * CHUNK;
        a_chunk  = CHUNK'(a_q >> shift);
        b_chunk  = CHUNK'(b_q >> shift);
        sum_full = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
        cout     = sum_full[CHUNK];
        // Merge the new chunk into its slot of the working sum; other bits keep their value.
        work_d   = (work_q & ~(LOW_MASK << shift))
                 | (WIDTH'(sum_full[CHUNK-1:0]) << shift);
        is_last  = (cnt_q == LAST);
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (is_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MULTI_CYCLE_ADDER_OVF_EN
    logic msb_cin;
    // Sum bit = a ^ b ^ cin, so the carry into the MSB can be recovered from the result.
    assign msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ work_d[WIDTH-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            S       <= '0;
            C       <= 1'b0;
            done    <= 1'b0;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
            V       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= X;
                        b_q     <= Y;
                        carry_q <= Z;
                        work_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    work_q  <= work_d;
                    carry_q <= cout;
                    if (is_last) begin
                        S     <= work_d;
                        C     <= cout;
                        done  <= 1'b1;
                        // Wrap to 0 rather than NCHUNK so the counter stays in range.
                        cnt_q <= '0;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
                        V     <= msb_cin ^ cout;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb/tb_multi_cycle_adder.sv - randomized self-checking bench for multi_cycle_adder (CHUNK 4, 16, 1)
module tb_multi_cycle_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [3];
    logic [15:0] X, Y;
    logic        Z;
    logic [15:0] s    [3];
    logic        c    [3];
    logic        busy [3];
    logic        done [3];
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    logic        v    [3];
`endif

    logic [15:0] exp_s [3];
    logic        exp_c [3];
    logic        exp_v [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start[0]), .X(X), .Y(Y), .Z(Z),
        .S(s[0]), .C(c[0]), .busy(busy[0]),
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        .done(done[0]), .V(v[0])
`else
        .done(done[0])
`endif
    );

    multi_cycle_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .start(start[1]), .X(X), .Y(Y), .Z(Z),
        .S(s[1]), .C(c[1]), .busy(busy[1]),
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        .done(done[1]), .V(v[1])
`else
        .done(done[1])
`endif
    );

    multi_cycle_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start[2]), .X(X), .Y(Y), .Z(Z),
        .S(s[2]), .C(c[2]), .busy(busy[2]),
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        .done(done[2]), .V(v[2])
`else
        .done(done[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nch(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Reference: full-width unsigned add and signed range test.
    task automatic model(input logic [15:0] x, input logic [15:0] y, input logic z,
                         output logic [15:0] rs, output logic rc, output logic rv);
        logic [16:0] u;
        int t;
        u  = {1'b0, x} + {1'b0, y} + 17'(z);
        rs = u[15:0];
        rc = u[16];
        t  = int'($signed(x)) + int'($signed(y)) + int'(z);
        rv = (t > 32767) || (t < -32768);
    endtask

    // Drives start for one cycle; returns at the first negedge after the accept edge.
    task automatic start_op(input int i, input logic [15:0] x, input logic [15:0] y, input logic z);
        @(negedge clk);
        start[i] = 1'b1;
        X = x; Y = y; Z = z;
        @(negedge clk);
        start[i] = 1'b0;
        X = 16'($urandom); Y = 16'($urandom); Z = 1'($urandom);
    endtask

    // Called at a negedge inside the run; counts cycles until done is seen.
    task automatic wait_done(input int i, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (done[i] !== 1'b1 && lat < 100) begin
            if (busy[i] === 1'b1) bc++;
            check("s_hold_while_busy", 32'(s[i]), 32'(exp_s[i]));
            @(negedge clk);
            lat++;
        end
        check("done_seen", 32'(done[i]), 32'd1);
    endtask

    task automatic check_result(input int i, input logic [15:0] x, input logic [15:0] y, input logic z);
        logic [15:0] rs;
        logic rc, rv;
        model(x, y, z, rs, rc, rv);
        exp_s[i] = rs;
        exp_c[i] = rc;
        exp_v[i] = rv;
        check("sum", 32'(s[i]), 32'(rs));
        check("carry_out", 32'(c[i]), 32'(rc));
        check("busy_at_done", 32'(busy[i]), 32'd0);
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        check("overflow", 32'(v[i]), 32'(rv));
`endif
    endtask

    task automatic run_op(input int i, input logic [15:0] x, input logic [15:0] y, input logic z);
        int lat, bc;
        start_op(i, x, y, z);
        wait_done(i, lat, bc);
        check("latency", 32'(lat), 32'(nch(i)));
        check("busy_cycles", 32'(bc), 32'(nch(i)));
        check_result(i, x, y, z);
        @(negedge clk);
        check("done_single_pulse", 32'(done[i]), 32'd0);
    endtask

    initial begin
        int lat, bc, dc;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            exp_s[i] = '0;
            exp_c[i] = 1'b0;
            exp_v[i] = 1'b0;
        end
        X = '0; Y = '0; Z = 1'b0;

        // Reset with start held high: nothing may be accepted.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) start[i] = 1'b1;
        X = 16'h1234; Y = 16'h4321; Z = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_s", 32'(s[i]), 32'd0);
            check("rst_c", 32'(c[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
`ifdef MULTI_CYCLE_ADDER_OVF_EN
            check("rst_v", 32'(v[i]), 32'd0);
`endif
            start[i] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed cases on CHUNK=4.
        run_op(0, 16'hA5A5, 16'h5A5A, 1'b1);
        run_op(0, 16'hFFFF, 16'h0000, 1'b0);
        run_op(0, 16'h7FFF, 16'h0001, 1'b0);
        run_op(0, 16'h8000, 16'h8000, 1'b0);

        // Start pulsed while busy is ignored; then start held through done.
        start_op(0, 16'h0003, 16'h0004, 1'b0);
        @(negedge clk);
        start[0] = 1'b1; X = 16'h1111; Y = 16'h1111; Z = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, lat, bc);
        check("ignored_start_latency", 32'(lat + 2), 32'd4);
        check_result(0, 16'h0003, 16'h0004, 1'b0);
        start[0] = 1'b1; X = 16'h1234; Y = 16'h0F0F; Z = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("b2b_done_low", 32'(done[0]), 32'd0);
        check("b2b_accepted", 32'(busy[0]), 32'd1);
        wait_done(0, lat, bc);
        check("b2b_latency", 32'(lat), 32'd4);
        check_result(0, 16'h1234, 16'h0F0F, 1'b1);
        @(negedge clk);

        // Abort in the middle of a run.
        start_op(0, 16'hBEEF, 16'h1357, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_s", 32'(s[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_s[i] = '0; exp_c[i] = 1'b0; exp_v[i] = 1'b0;
        end
        dc = 0;
        repeat (6) begin
            @(negedge clk);
            if (done[0] === 1'b1) dc++;
        end
        check("abort_no_done", 32'(dc), 32'd0);
        check("abort_idle", 32'(busy[0]), 32'd0);
        run_op(0, 16'h000F, 16'h0001, 1'b0);

        // Boundary instances.
        run_op(1, 16'hFFFF, 16'h0001, 1'b0);
        run_op(2, 16'hFFFF, 16'h0001, 1'b0);

        // Randomized operations on every instance.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 20; k++) begin
                run_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
